sipo_frame_rx: RTL
==================

Name: sipo_frame_rx

Overview:
- Serial-in/parallel-out frame receiver.
- Sits directly downstream of the team's PISO shifter and reassembles MSB-first serial bits into WIDTH-bit words.
- Uses a start/stop framing and a bit-strobe qualifier, and reports good frames with a one-cycle valid pulse.
- Malformed frames are flagged with a one-cycle error pulse.

Parameters:
- WIDTH, 3, data bits per frame, ≥1. Matches the 3-bit PISO word.
- CNT_W, $clog2(WIDTH+1), bit-counter width. Derived; do not override.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- bit_en  input  1  bit strobe; serial_in is sampled only on cycles where bit_en=1
- serial_in  input  1  serial line; idle level 0
- data_out  output  WIDTH  last good frame, MSB = first data bit received
- data_valid  output  1  one-cycle pulse; data_out was updated this cycle
- frame_err  output  1  one-cycle pulse; framing (or parity) error detected
- busy  output  1  high whenever FSM is not in IDLE

Behaviour:
- Reset: asynchronous, active-high.
  - State = IDLE; shift register, bit counter, data_out all zero.
  - data_valid = 0, frame_err = 0, busy = 0.
  - Asserting reset mid-frame aborts the frame with no valid or error pulse.
- Sampling: all FSM transitions and shifts occur only on clk edges where bit_en=1. Cycles with bit_en=0 hold all state.
- Frame format, one bit per strobe:
  - Start bit = 1.
  - WIDTH data bits, MSB first.
  - [parity bit, see Optional Feature].
  - Stop bit = 0.
- FSM states: IDLE, DATA, PARITY (exists only when feature enabled), STOP.
  - IDLE: serial_in=1 → DATA, bit counter := 0. serial_in=0 → stay.
  - DATA: shift_reg := {shift_reg[WIDTH-2:0], serial_in}; counter += 1. After the WIDTH-th data bit → PARITY if enabled, else STOP.
  - STOP, serial_in=0: data_out := shift_reg; data_valid pulses on the following cycle edge (registered); → IDLE.
  - STOP, serial_in=1: frame_err pulses; data_out unchanged; → IDLE. This 1 is NOT taken as a new start bit.
- Timing and pulses:
  - Latency: data_valid asserts one clk after the edge that sampled the stop bit.
  - data_valid and frame_err are never both high.
  - Each pulse is exactly one clk cycle wide, regardless of bit_en.
- Back-to-back frames: a start bit on the strobe immediately after the stop strobe is accepted. No extra idle bit is required.
- WIDTH=1: DATA lasts one strobe. Counter logic must handle it.
- busy: combinational from state (state != IDLE).

Optional Feature:
- Macro: SIPO_FRAME_RX_PARITY_EN.
- Defined:
  - PARITY state is inserted after DATA.
  - The sampled bit must make XOR(data bits, parity bit) = 0 (even parity).
  - On mismatch, the stop bit is still consumed. At STOP, frame_err pulses instead of data_valid, and data_out is unchanged.
  - A parity error and a bad stop bit in the same frame produce a single frame_err pulse.
  - Frame length is WIDTH+3 strobes.
- Undefined: no PARITY state or parity logic; frame length is WIDTH+2 strobes.

Test Plan:
- Reset then bit_en=1 constantly, serial_in = 1,1,0,1,0 (WIDTH=3) → data_out=3'b101, data_valid pulse 1 cycle after stop sample, frame_err=0, busy high for 4 cycles.
- Same frame with bit_en=1 only every 4th cycle → identical data_out=3'b101. State holds between strobes; exactly one data_valid pulse.
- Frame 1,0,1,1,1 (bad stop) → frame_err one-cycle pulse, data_out keeps previous 3'b101. FSM returns to IDLE, and the next strobe with 0 keeps it IDLE.
- Back-to-back 1,0,1,0,0 then 1,1,1,1,0 → data_valid twice, data_out = 3'b010 then 3'b111.
- Assert reset after 3 bits of a frame → all outputs 0 immediately (asynchronous). A subsequent clean frame 1,0,0,1,0 → data_out=3'b001.
- With SIPO_FRAME_RX_PARITY_EN:
  - 1,1,0,1,0,0 (even parity OK) → data_out=3'b101, data_valid.
  - 1,1,0,1,1,0 (parity bad) → frame_err, no data_valid.

Source files
------------

// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx: serial-in/parallel-out frame receiver.
// Reassembles MSB-first serial data framed as start(1) / WIDTH data bits /
// [even parity] / stop(0). The receiver advances only on bit_en strobes.
// It reports a good frame with a one-cycle data_valid pulse and a malformed
// frame with a one-cycle frame_err pulse.
// Optional feature macro: SIPO_FRAME_RX_PARITY_EN. When it is defined, an
// even-parity bit is expected between the last data bit and the stop bit.
module sipo_frame_rx #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
`ifdef SIPO_FRAME_RX_PARITY_EN
  localparam logic [1:0] ST_PARITY = 2'd2;
`endif
  localparam logic [1:0] ST_STOP   = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_nxt;
  logic [WIDTH-1:0] shift_in;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic             valid_nxt;
  logic             err_nxt;
  logic             stop_good;
`ifdef SIPO_FRAME_RX_PARITY_EN
  logic             parity_bad;
  logic             parity_bad_nxt;
`endif

  // Shift-in value; the WIDTH=1 case has no upper bits to keep
  generate
    if (WIDTH == 1) begin : g_shift_w1
      assign shift_in = serial_in;
    end else begin : g_shift_wn
      assign shift_in = {shift_reg[WIDTH-2:0], serial_in};
    end
  endgenerate

  // busy is decoded straight from the state register
  assign busy = (state != ST_IDLE);

  // Next-state, datapath and pulse decode; everything holds unless strobed
  always_comb begin
    state_nxt = state;
    shift_nxt = shift_reg;
    cnt_nxt   = cnt;
    data_nxt  = data_out;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
`ifdef SIPO_FRAME_RX_PARITY_EN
    parity_bad_nxt = parity_bad;
    stop_good      = !serial_in && !parity_bad;
`else
    stop_good      = !serial_in;
`endif
    if (bit_en) begin
      case (state)
        ST_IDLE: begin
          if (serial_in) begin
            state_nxt = ST_DATA;
            cnt_nxt   = '0;
`ifdef SIPO_FRAME_RX_PARITY_EN
            parity_bad_nxt = 1'b0;
`endif
          end
        end
        ST_DATA: begin
          shift_nxt = shift_in;
          cnt_nxt   = cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
`ifdef SIPO_FRAME_RX_PARITY_EN
            state_nxt = ST_PARITY;
`else
            state_nxt = ST_STOP;
`endif
          end
        end
`ifdef SIPO_FRAME_RX_PARITY_EN
        ST_PARITY: begin
          parity_bad_nxt = (^shift_reg) ^ serial_in;
          state_nxt      = ST_STOP;
        end
`endif
        ST_STOP: begin
          // A high stop bit ends the frame; it is never a new start bit
          if (stop_good) begin
            data_nxt  = shift_reg;
            valid_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
          state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath and output registers; pulses self-clear every clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg  <= '0;
      cnt        <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      shift_reg  <= shift_nxt;
      cnt        <= cnt_nxt;
      data_out   <= data_nxt;
      data_valid <= valid_nxt;
      frame_err  <= err_nxt;
    end
  end

`ifdef SIPO_FRAME_RX_PARITY_EN
  // Parity verdict for the frame in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_bad <= 1'b0;
    end else begin
      parity_bad <= parity_bad_nxt;
    end
  end
`endif

endmodule
